// File: rtl/tcp_tx_arbiter.sv
// Round-robin arbiter sharing one TCP encoder between N_REQ payload sources.
// Streams the owner's words to the encoder, then waits for fin (or a timeout) before releasing.
module tcp_tx_arbiter #(
    parameter int N_REQ   = 4,
    parameter int IDX_W   = 2,
    parameter int FIN_TMO = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req,
    input  logic [16*N_REQ-1:0]   req_len,
    input  logic [32*N_REQ-1:0]   src_data,
    input  logic [N_REQ-1:0]      src_av,
    output logic [N_REQ-1:0]      src_rd,
    output logic [IDX_W-1:0]      grant_idx,
    output logic                  busy,
    output logic                  enc_start,
    output logic [31:0]           enc_data,
    output logic                  enc_av,
    output logic [15:0]           enc_len,
    input  logic                  enc_fin,
    output logic [N_REQ-1:0]      done,
    output logic [N_REQ-1:0]      err
);

    typedef enum logic [1:0] {IDLE, STREAM, WAIT_FIN, RELEASE} state_t;

    localparam int TMO_W = (FIN_TMO > 2) ? $clog2(FIN_TMO) : 1;
    localparam int WL_W  = 15;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
    logic               busy_q, busy_d;
    logic [15:0]        enc_len_q, enc_len_d;
    logic [WL_W-1:0]    words_left_q, words_left_d;
    logic               first_q, first_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic [N_REQ-1:0]   err_q, err_d;

    logic               pick_found_s;
    logic [IDX_W-1:0]   pick_idx_s;
    logic [IDX_W:0]     cand_s;
    logic [15:0]        pick_len_s;
    logic [16:0]        len_sum_s;
    logic               g_av_s;
    logic [31:0]        g_data_s;
    logic [N_REQ-1:0]   onehot_s;
    logic               accept_s;

    // Cyclic search for the first request at or after rr_ptr
    always_comb begin
        pick_found_s = 1'b0;
        pick_idx_s   = '0;
        cand_s       = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand_s = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
            if (cand_s >= (IDX_W+1)'(N_REQ)) begin
                cand_s = cand_s - (IDX_W+1)'(N_REQ);
            end else begin
                cand_s = cand_s;
            end
            if (!pick_found_s && req[cand_s[IDX_W-1:0]]) begin
                pick_found_s = 1'b1;
                pick_idx_s   = cand_s[IDX_W-1:0];
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // Source muxes: length of the candidate, data/valid of the owner
    always_comb begin
        pick_len_s = 16'd0;
        g_av_s     = 1'b0;
        g_data_s   = 32'd0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_idx_s == IDX_W'(i)) begin
                pick_len_s = req_len[i*16 +: 16];
            end else begin
                pick_len_s = pick_len_s;
            end
            if (grant_idx_q == IDX_W'(i)) begin
                g_av_s   = src_av[i];
                g_data_s = src_data[i*32 +: 32];
            end else begin
                g_av_s   = g_av_s;
                g_data_s = g_data_s;
            end
        end
    end

    assign len_sum_s = {1'b0, pick_len_s} + 17'd3;
    assign onehot_s  = {{(N_REQ-1){1'b0}}, 1'b1} << grant_idx_q;
    assign accept_s  = (state_q == STREAM) && (words_left_q != '0) && g_av_s;

    // Encoder-facing stream signals follow the owner combinationally
    always_comb begin
        enc_av    = accept_s;
        src_rd    = accept_s ? onehot_s : '0;
        enc_data  = (state_q == STREAM) ? g_data_s : 32'd0;
        enc_start = (state_q == STREAM) && first_q && (accept_s || (words_left_q == '0));
    end

    // Next-state and registered-output computation
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        grant_idx_d  = grant_idx_q;
        busy_d       = busy_q;
        enc_len_d    = enc_len_q;
        words_left_d = words_left_q;
        first_d      = first_q;
        tmo_d        = tmo_q;
        done_d       = '0;
        err_d        = '0;
        case (state_q)
            IDLE: begin
                if (pick_found_s) begin
                    grant_idx_d  = pick_idx_s;
                    enc_len_d    = pick_len_s;
                    words_left_d = len_sum_s[16:2];
                    busy_d       = 1'b1;
                    first_d      = 1'b1;
                    state_d      = STREAM;
                end else begin
                    state_d = IDLE;
                end
            end
            STREAM: begin
                if (words_left_q == '0) begin
                    first_d = 1'b0;
                    tmo_d   = '0;
                    state_d = WAIT_FIN;
                end else if (accept_s) begin
                    first_d      = 1'b0;
                    words_left_d = words_left_q - WL_W'(1);
                    if (words_left_q == WL_W'(1)) begin
                        tmo_d   = '0;
                        state_d = WAIT_FIN;
                    end else begin
                        state_d = STREAM;
                    end
                end else begin
                    state_d = STREAM;
                end
            end
            WAIT_FIN: begin
                // fin takes priority over a coincident timeout
                if (enc_fin) begin
                    done_d  = onehot_s;
                    busy_d  = 1'b0;
                    state_d = RELEASE;
                end else if (tmo_q == TMO_W'(FIN_TMO - 1)) begin
                    err_d   = onehot_s;
                    busy_d  = 1'b0;
                    state_d = RELEASE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            RELEASE: begin
                if (grant_idx_q == IDX_W'(N_REQ - 1)) begin
                    rr_ptr_d = '0;
                end else begin
                    rr_ptr_d = grant_idx_q + IDX_W'(1);
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            grant_idx_q  <= '0;
            busy_q       <= 1'b0;
            enc_len_q    <= 16'd0;
            words_left_q <= '0;
            first_q      <= 1'b0;
            tmo_q        <= '0;
            done_q       <= '0;
            err_q        <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_idx_q  <= grant_idx_d;
            busy_q       <= busy_d;
            enc_len_q    <= enc_len_d;
            words_left_q <= words_left_d;
            first_q      <= first_d;
            tmo_q        <= tmo_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign grant_idx = grant_idx_q;
    assign busy      = busy_q;
    assign enc_len   = enc_len_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_tcp_tx_arbiter.sv
// Directed self-checking bench for tcp_tx_arbiter (N_REQ=4, FIN_TMO=16).
module tb_tcp_tx_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req;
    logic [63:0]  req_len;
    logic [127:0] src_data;
    logic [3:0]   src_av;
    logic [3:0]   src_rd;
    logic [1:0]   grant_idx;
    logic         busy;
    logic         enc_start;
    logic [31:0]  enc_data;
    logic         enc_av;
    logic [15:0]  enc_len;
    logic         enc_fin;
    logic [3:0]   done;
    logic [3:0]   err;

    int n_cmp = 0;
    int n_err = 0;

    tcp_tx_arbiter #(.N_REQ(4), .IDX_W(2), .FIN_TMO(16)) dut (
        .clk(clk), .reset(reset), .req(req), .req_len(req_len),
        .src_data(src_data), .src_av(src_av), .src_rd(src_rd),
        .grant_idx(grant_idx), .busy(busy), .enc_start(enc_start),
        .enc_data(enc_data), .enc_av(enc_av), .enc_len(enc_len),
        .enc_fin(enc_fin), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_g[5];
        int bad;
        exp_g = '{0, 1, 2, 3, 0};
        reset = 1'b1; req = '0; req_len = '0; src_data = '0; src_av = '0; enc_fin = 1'b0;
        cyc(); cyc();
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant_idx, 0);
        chk("rst_len", enc_len, 0);
        chk("rst_av", enc_av, 0);
        chk("rst_done", done, 0);
        reset = 1'b0;

        // 1: single packet, 11 bytes -> 3 words
        req = 4'b0001; req_len[15:0] = 16'd11; src_av = 4'b1111; src_data[31:0] = 32'hA000_0001;
        #1; chk("t1_idle_busy", busy, 0);
        cyc(); #1;
        chk("t1_w1_start", enc_start, 1); chk("t1_w1_av", enc_av, 1);
        chk("t1_w1_rd", src_rd, 4'b0001); chk("t1_w1_data", enc_data, 32'hA000_0001);
        chk("t1_grant", grant_idx, 0); chk("t1_len", enc_len, 11); chk("t1_busy", busy, 1);
        cyc(); src_data[31:0] = 32'hA000_0002; #1;
        chk("t1_w2_start", enc_start, 0); chk("t1_w2_av", enc_av, 1);
        chk("t1_w2_data", enc_data, 32'hA000_0002);
        cyc(); src_data[31:0] = 32'hA000_0003; #1;
        chk("t1_w3_av", enc_av, 1); chk("t1_w3_rd", src_rd, 4'b0001);
        cyc(); #1;
        chk("t1_wf_av", enc_av, 0); chk("t1_wf_rd", src_rd, 0); chk("t1_wf_busy", busy, 1);
        enc_fin = 1'b1;
        cyc(); enc_fin = 1'b0; req = '0; #1;
        chk("t1_done", done, 4'b0001); chk("t1_err", err, 0); chk("t1_rel_busy", busy, 0);
        cyc(); #1;
        chk("t1_done_pulse", done, 0); chk("t1_idle_busy2", busy, 0);

        // 2: stalled source, src_av pattern 1,0,1,1
        req = 4'b0001;
        cyc(); src_av = 4'b0001; #1;
        chk("t2_c1_start", enc_start, 1); chk("t2_c1_av", enc_av, 1); chk("t2_c1_rd", src_rd, 4'b0001);
        cyc(); src_av = 4'b0000; #1;
        chk("t2_c2_start", enc_start, 0); chk("t2_c2_av", enc_av, 0); chk("t2_c2_rd", src_rd, 0);
        chk("t2_c2_busy", busy, 1);
        cyc(); src_av = 4'b0001; #1;
        chk("t2_c3_start", enc_start, 0); chk("t2_c3_av", enc_av, 1); chk("t2_c3_rd", src_rd, 4'b0001);
        cyc(); #1;
        chk("t2_c4_av", enc_av, 1); chk("t2_c4_rd", src_rd, 4'b0001);
        cyc(); #1;
        chk("t2_wf_av", enc_av, 0); chk("t2_wf_rd", src_rd, 0);
        enc_fin = 1'b1;
        cyc(); enc_fin = 1'b0; req = '0; #1;
        chk("t2_done", done, 4'b0001);
        cyc();

        // 3: round robin from a fresh reset
        reset = 1'b1; cyc(); cyc(); reset = 1'b0;
        req = 4'b1111; req_len = {16'd4, 16'd4, 16'd4, 16'd4}; src_av = 4'b1111;
        for (int p = 0; p < 5; p++) begin
            cyc(); #1;
            chk("t3_grant", grant_idx, exp_g[p]);
            chk("t3_rd", src_rd, 4'b0001 << exp_g[p]);
            chk("t3_start", enc_start, 1);
            cyc(); enc_fin = 1'b1; #1;
            cyc(); enc_fin = 1'b0;
            if (p == 4) req = '0;
            #1;
            chk("t3_done", done, 4'b0001 << exp_g[p]);
            cyc();
        end

        // 4: zero length on source 2
        req = 4'b0100; req_len[47:32] = 16'd0;
        cyc(); #1;
        chk("t4_start", enc_start, 1); chk("t4_av", enc_av, 0); chk("t4_rd", src_rd, 0);
        chk("t4_grant", grant_idx, 2);
        cyc(); #1;
        chk("t4_wf_start", enc_start, 0); chk("t4_wf_busy", busy, 1);

        // 5a: no fin -> err 16 cycles after WAIT_FIN entry
        bad = 0;
        for (int k = 1; k < 16; k++) begin
            cyc(); #1;
            if (err !== 4'b0000 || done !== 4'b0000) bad++;
        end
        chk("t5_early_pulse", bad, 0);
        cyc(); req = '0; #1;
        chk("t5_err", err, 4'b0100); chk("t5_no_done", done, 0); chk("t5_busy", busy, 0);
        cyc(); #1;
        chk("t5_err_pulse", err, 0);

        // 5b: fin on the 16th WAIT_FIN cycle wins over timeout
        req = 4'b0010;
        cyc(); #1;
        chk("t5b_grant", grant_idx, 1); chk("t5b_av", enc_av, 1);
        cyc();
        for (int k = 1; k < 16; k++) begin
            cyc();
            if (k == 15) enc_fin = 1'b1;
        end
        cyc(); enc_fin = 1'b0; req = '0; #1;
        chk("t5b_done", done, 4'b0010); chk("t5b_no_err", err, 0);
        cyc();

        // 6: reset in the middle of a long packet
        req = 4'b1000; req_len[63:48] = 16'd40;
        cyc(); #1;
        chk("t6_grant", grant_idx, 3); chk("t6_busy", busy, 1);
        cyc(); reset = 1'b1; #1;
        cyc(); reset = 1'b0; req = '0; #1;
        chk("t6_busy", busy, 0); chk("t6_grant0", grant_idx, 0); chk("t6_len", enc_len, 0);
        chk("t6_av", enc_av, 0); chk("t6_start", enc_start, 0); chk("t6_rd", src_rd, 0);
        chk("t6_data", enc_data, 0); chk("t6_done", done, 0); chk("t6_err", err, 0);
        cyc(); #1;
        chk("t6_done2", done, 0); chk("t6_err2", err, 0);
        req = 4'b1111;
        cyc(); #1;
        chk("t6_rr_ptr0", grant_idx, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
